// File: rtl/sram_wb_pkg.sv
// Shared types and sizing helpers for the Wishbone SRAM controller.
package sram_wb_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned addr_w_of(input int unsigned words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/sram_wb_array.sv
// Byte-enable write, registered read storage array; shared by zero-fill and bus paths.
module sram_wb_array
  import sram_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 256
) (
  input  logic                                 CLK,
  input  logic [DATA_W/8-1:0]                  we,
  input  logic                                 en,
  input  logic [addr_w_of(WORDS)-1:0]          addr,
  input  logic [DATA_W-1:0]                    din,
  output logic [DATA_W-1:0]                    dout
);

  localparam int unsigned NB = bytes_of(DATA_W);

  logic [DATA_W-1:0] mem [WORDS];

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge CLK) begin
    if (en) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= din[8*b +: 8];
        end
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone-classic SRAM slave with post-reset zero-fill and 1- or 2-cycle read latency.
// Optional simulation trace: define RAM_TRACE_EN.
module sram_wb_ctrl
  import sram_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WORDS    = 256,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  init_done_o
);

  localparam int unsigned ADDR_W = addr_w_of(WORDS);
  localparam int unsigned NB     = bytes_of(DATA_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                rd_q, rd_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   stage_q, stage_d;

  logic                req;
  logic [ADDR_W-1:0]   word;
  logic                arr_en;
  logic [NB-1:0]       arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_din;
  logic [DATA_W-1:0]   arr_dout;
  logic [DATA_W-1:0]   rd_data;
  logic                unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign word       = wb_adr_i[ADDR_W+1:2];
  assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

  sram_wb_array #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_array (
    .CLK  (CLK),
    .we   (arr_we),
    .en   (arr_en),
    .addr (arr_addr),
    .din  (arr_din),
    .dout (arr_dout)
  );

  // Next-state, array port steering and ack generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    rd_d     = rd_q;
    done_d   = done_q;
    stage_d  = stage_q;
    arr_en   = 1'b0;
    arr_we   = '0;
    arr_addr = word;
    arr_din  = wb_dat_i;

    unique case (state_q)
      ST_INIT: begin
        arr_en   = 1'b1;
        arr_we   = '1;
        arr_addr = cnt_q;
        arr_din  = '0;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(WORDS - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          arr_en = 1'b1;
          arr_we = wb_we_i ? wb_sel_i : '0;
          rd_d   = ~wb_we_i;
          if (wb_we_i || READ_LAT == 1) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        stage_d = arr_dout;
        if (wb_cyc_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      stage_q <= stage_d;
    end
  end

  // Data is gated to zero outside a read ack so reset clears the bus at once.
  assign rd_data     = (READ_LAT == 2) ? stage_q : arr_dout;
  assign wb_dat_o    = (ack_q && rd_q) ? rd_data : '0;
  assign wb_ack_o    = ack_q;
  assign init_done_o = done_q;

`ifdef RAM_TRACE_EN
  logic [ADDR_W-1:0] tr_word_q;
  logic [NB-1:0]     tr_sel_q;
  logic [DATA_W-1:0] tr_wdat_q;
  logic              tr_we_q;

  always_ff @(posedge CLK) begin
    if (state_q == ST_IDLE && req) begin
      tr_word_q <= word;
      tr_sel_q  <= wb_sel_i;
      tr_wdat_q <= wb_dat_i;
      tr_we_q   <= wb_we_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (ack_q) begin
      $display("%0t sram %s word=%h sel=%h data=%h", $time, tr_we_q ? "W" : "R",
               tr_word_q, tr_sel_q, tr_we_q ? tr_wdat_q : wb_dat_o);
    end
    if (done_d && !done_q) begin
      $display("%0t sram INIT DONE", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Directed bench: READ_LAT=1 and READ_LAT=2 instances on a shared clock and reset.
module tb_sram_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc1 = 1'b0, stb1 = 1'b0, cyc2 = 1'b0, stb2 = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_sel = 4'h0;
  logic [31:0] bus_adr = 32'h0;
  logic [31:0] bus_dat = 32'h0;
  logic [31:0] dat1, dat2;
  logic        ack1, ack2, done1, done2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_wb_ctrl #(.DATA_W(32), .WORDS(256), .READ_LAT(1)) u_dut1 (
    .CLK(clk), .RESETn(rst_n), .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_we_i(bus_we),
    .wb_sel_i(bus_sel), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .init_done_o(done1)
  );

  sram_wb_ctrl #(.DATA_W(32), .WORDS(256), .READ_LAT(2)) u_dut2 (
    .CLK(clk), .RESETn(rst_n), .wb_cyc_i(cyc2), .wb_stb_i(stb2), .wb_we_i(bus_we),
    .wb_sel_i(bus_sel), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
    .wb_dat_o(dat2), .wb_ack_o(ack2), .init_done_o(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on instance d; returns read data and edges from request to ack.
  task automatic bus(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bus_we = we; bus_adr = adr; bus_sel = sel; bus_dat = wd;
    if (d == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else        begin cyc2 = 1'b1; stb2 = 1'b1; end
    lat = -1;
    rd  = 'x;
    for (int n = 1; n <= 400 && lat < 0; n++) begin
      @(posedge clk); #1;
      if ((d == 1 && ack1) || (d == 2 && ack2)) begin
        lat = n;
        rd  = (d == 1) ? dat1 : dat2;
      end
    end
    cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
    if (lat < 0) chk("ack_timeout", 32'(lat), 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, (d == 1) ? ack1 : ack2}, 32'd0);
    chk("dat_idle_zero", (d == 1) ? dat1 : dat2, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int n;
    int seen;

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_dat1", dat1, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_ack2", {31'd0, ack2}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill duration
    n = 0;
    while (!done1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fill_cycles", 32'(n), 32'd256);
    chk("fill_done2", {31'd0, done2}, 32'd1);

    for (int w = 0; w < 256; w++) begin
      bus(1, 1'b0, 32'(w * 4), 4'hF, 32'h0, rd, lat);
      chk("zero_fill", rd, 32'h0);
    end

    // Basic write/read and latency
    bus(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
    chk("wr_lat1", 32'(lat), 32'd1);
    bus(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("rd_lat1", 32'(lat), 32'd1);
    chk("rd_data1", rd, 32'hDEADBEEF);
    bus(2, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
    chk("wr_lat2", 32'(lat), 32'd1);
    bus(2, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("rd_lat2", 32'(lat), 32'd2);
    chk("rd_data2", rd, 32'hDEADBEEF);

    // Byte lanes
    bus(1, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, lat);
    bus(1, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, rd, lat);
    bus(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    chk("sel_5_merge", rd, 32'h11BB33DD);
    bus(1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, rd, lat);
    chk("sel_0_ack_lat", 32'(lat), 32'd1);
    bus(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    chk("sel_0_unchanged", rd, 32'h11BB33DD);
    bus(1, 1'b1, 32'h20, 4'h8, 32'h99000000, rd, lat);
    bus(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    chk("sel_8_top", rd, 32'h99BB33DD);

    // Read aborted in RWAIT
    bus(2, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, rd, lat);
    bus_we = 1'b0; bus_adr = 32'h30; bus_sel = 4'hF;
    cyc2 = 1'b1; stb2 = 1'b1;
    @(posedge clk); #1;
    cyc2 = 1'b0; stb2 = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack2) seen++;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    bus(2, 1'b0, 32'h30, 4'hF, 32'h0, rd, lat);
    chk("post_abort_lat", 32'(lat), 32'd2);
    chk("post_abort_data", rd, 32'hCAFEF00D);

    // Reset asserted during a read ack
    bus_we = 1'b0; bus_adr = 32'h10; bus_sel = 4'hF;
    cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ack", {31'd0, ack1}, 32'd1);
    chk("pre_rst_dat", dat1, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {31'd0, ack1}, 32'd0);
    chk("mid_rst_dat", dat1, 32'd0);
    chk("mid_rst_done", {31'd0, done1}, 32'd0);
    cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Request held through the fill, aliased address
    bus(1, 1'b0, 32'h400, 4'hF, 32'h0, rd, lat);
    chk("pending_lat", 32'(lat), 32'd257);
    chk("pending_data", rd, 32'h0);
    bus(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("refill_lost1", rd, 32'h0);
    bus(2, 1'b0, 32'h30, 4'hF, 32'h0, rd, lat);
    chk("refill_lost2", rd, 32'h0);
    bus(1, 1'b1, 32'h400, 4'hF, 32'h5A5A5A5A, rd, lat);
    bus(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat);
    chk("alias_400_w0", rd, 32'h5A5A5A5A);
    bus(1, 1'b0, 32'h800, 4'hF, 32'h0, rd, lat);
    chk("alias_800_w0", rd, 32'h5A5A5A5A);
    bus(1, 1'b1, 32'hFFC, 4'hF, 32'h0BADF00D, rd, lat);
    bus(1, 1'b0, 32'h3FC, 4'hF, 32'h0, rd, lat);
    chk("alias_top_word", rd, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
